// File: rtl/instr_word_loader_if.sv
// Bus interfaces for instr_word_loader: the mnemonic-level instruction handshake
// and the byte-wide instruction-memory write port with BUSYWAIT stall.

interface iwl_instr_if;
  logic       valid;
  logic       ready;
  logic [4:0] mnemonic;
  logic [2:0] rd;
  logic [2:0] rt;
  logic [2:0] rs;
  logic [7:0] imm;
  logic [7:0] offset;

  modport master (output valid, mnemonic, rd, rt, rs, imm, offset, input ready);
  modport slave  (input valid, mnemonic, rd, rt, rs, imm, offset, output ready);
endinterface

interface iwl_mem_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              write;
  logic              busywait;

  modport master (output addr, wdata, write, input busywait);
  modport slave  (input addr, wdata, write, output busywait);
endinterface

// File: rtl/instr_word_loader.sv
// Program loader: encodes mnemonics into 32-bit words, queues them, writes bytes little-endian.
// Optional LOADER_CHECKSUM_EN adds checksum_o, the mod-256 sum of accepted bytes since START/reset.

module instr_word_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  iwl_instr_if.slave        in_if,
  iwl_mem_if.master         mem_if,
  output logic [15:0]       count_o,
  output logic              busy_o,
  output logic              err_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [4:0] OP_LOADI = 5'd0;
  localparam logic [4:0] OP_MOV   = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_J     = 5'd6;
  localparam logic [4:0] OP_BEQ   = 5'd7;
  localparam logic [4:0] OP_MULT  = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_ROR   = 5'd12;
  localparam logic [4:0] OP_BNE   = 5'd13;
  localparam logic [4:0] OP_LWD   = 5'd14;
  localparam logic [4:0] OP_LWI   = 5'd15;
  localparam logic [4:0] OP_SWD   = 5'd16;
  localparam logic [4:0] OP_SWI   = 5'd17;

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;

  state_t            state_q;
  logic [31:0]       hold_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_inc;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic [15:0]       count_q;
  logic              err_q;

  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q;
  logic [PTR_W:0]    rd_ptr_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic [31:0]       fifo_head;

  logic [7:0]        f2;
  logic [7:0]        f1;
  logic [7:0]        f0;
  logic              enc_legal;
  logic [31:0]       enc_word;

  logic              handshake;
  logic              push;
  logic              pop;
  logic              accept;
  logic              start_ok;

  always_comb begin
    enc_legal = 1'b1;
    f2        = 8'h00;
    f1        = 8'h00;
    f0        = 8'h00;
    case (in_if.mnemonic)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MULT: begin
        f2 = {5'b0, in_if.rd};
        f1 = {5'b0, in_if.rt};
        f0 = {5'b0, in_if.rs};
      end
      OP_MOV, OP_LWD: begin
        f2 = {5'b0, in_if.rd};
        f0 = {5'b0, in_if.rs};
      end
      OP_LOADI, OP_LWI, OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
        f2 = {5'b0, in_if.rd};
        f0 = in_if.imm;
      end
      OP_J: begin
        f2 = in_if.offset;
      end
      OP_BEQ, OP_BNE: begin
        f2 = in_if.offset;
        f1 = {5'b0, in_if.rt};
        f0 = {5'b0, in_if.rs};
      end
      OP_SWD: begin
        f1 = {5'b0, in_if.rt};
        f0 = {5'b0, in_if.rs};
      end
      OP_SWI: begin
        f1 = {5'b0, in_if.rt};
        f0 = in_if.imm;
      end
      default: enc_legal = 1'b0;
    endcase
  end

  assign enc_word   = {3'b000, in_if.mnemonic, f2, f1, f0};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

  assign in_if.ready = !fifo_full;
  assign handshake   = in_if.valid && !fifo_full;
  assign push        = handshake && enc_legal;
  assign accept      = mem_write_q && !mem_if.busywait;
  // Pop either from idle or on the last byte's acceptance, so words stream with no bubble.
  assign pop         = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_B3) && accept));
  assign busy_o      = !fifo_empty || (state_q != S_IDLE);
  assign start_ok    = start_i && !busy_o;
  assign ptr_inc     = ptr_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      ptr_q       <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        ptr_q   <= base_addr_i;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if (handshake && !enc_legal) err_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            hold_q      <= fifo_head;
            state_q     <= S_B0;
            mem_write_q <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= fifo_head[7:0];
          end
        end
        S_B0: begin
          if (accept) begin
            ptr_q       <= ptr_inc;
            mem_addr_q  <= ptr_inc;
            mem_wdata_q <= hold_q[15:8];
            state_q     <= S_B1;
          end
        end
        S_B1: begin
          if (accept) begin
            ptr_q       <= ptr_inc;
            mem_addr_q  <= ptr_inc;
            mem_wdata_q <= hold_q[23:16];
            state_q     <= S_B2;
          end
        end
        S_B2: begin
          if (accept) begin
            ptr_q       <= ptr_inc;
            mem_addr_q  <= ptr_inc;
            mem_wdata_q <= hold_q[31:24];
            state_q     <= S_B3;
          end
        end
        S_B3: begin
          if (accept) begin
            ptr_q      <= ptr_inc;
            mem_addr_q <= ptr_inc;
            count_q    <= count_q + 16'd1;
            if (!fifo_empty) begin
              hold_q      <= fifo_head;
              mem_wdata_q <= fifo_head[7:0];
              state_q     <= S_B0;
            end else begin
              mem_write_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (start_ok) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + mem_wdata_q;
    end
  end

  assign checksum_o = checksum_q;
`endif

  assign mem_if.write = mem_write_q;
  assign mem_if.addr  = mem_addr_q;
  assign mem_if.wdata = mem_wdata_q;
  assign count_o      = count_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_instr_word_loader.sv
// Directed testbench for instr_word_loader: hand-encoded words checked byte by byte
// against a log of every memory write the loader issues.

module tb_instr_word_loader;

  logic       clk;
  logic       rst;
  logic       startIn;
  logic [9:0] baseAddr;
  logic [15:0] countOut;
  logic       busyOut;
  logic       errOut;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksumOut;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hsCyc = 0;

  logic [9:0] logAddr[$];
  logic [7:0] logData[$];
  int         logCyc[$];
  logic [9:0] expAddr[$];
  logic [7:0] expData[$];

  iwl_instr_if            inBus ();
  iwl_mem_if #(.ADDR_W(10)) memBus ();

  instr_word_loader #(.ADDR_W(10), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (startIn),
    .base_addr_i(baseAddr),
    .in_if      (inBus),
    .mem_if     (memBus),
    .count_o    (countOut),
    .busy_o     (busyOut),
    .err_o      (errOut)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum_o (checksumOut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // A byte seen at the negedge with write high and no stall is accepted at the next edge.
  always @(negedge clk) begin
    if (!rst && memBus.write && !memBus.busywait) begin
      logAddr.push_back(memBus.addr);
      logData.push_back(memBus.wdata);
      logCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    logCyc.delete();
  endtask

  task automatic expectWord(input logic [31:0] word, input logic [9:0] startAddr);
    logic [9:0] a;
    a = startAddr;
    for (int i = 0; i < 4; i++) begin
      expAddr.push_back(a);
      expData.push_back(word[8*i +: 8]);
      a = a + 10'd1;
    end
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, "_len"}, 32'(logData.size()), 32'(expData.size()));
    for (int i = 0; i < expData.size(); i++) begin
      if (i < logData.size()) begin
        checkOutput({tag, "_addr"}, 32'(logAddr[i]), 32'(expAddr[i]));
        checkOutput({tag, "_data"}, 32'(logData[i]), 32'(expData[i]));
      end else begin
        checkOutput({tag, "_missing"}, 32'hFFFF_FFFF, 32'(expData[i]));
      end
    end
    expAddr.delete();
    expData.delete();
  endtask

  task automatic applyStimulus(input logic [4:0] mn, input logic [2:0] rd, input logic [2:0] rt,
                               input logic [2:0] rs, input logic [7:0] imm, input logic [7:0] off,
                               input bit doStart, input logic [9:0] base);
    bit got;
    inBus.valid    = 1'b1;
    inBus.mnemonic = mn;
    inBus.rd       = rd;
    inBus.rt       = rt;
    inBus.rs       = rs;
    inBus.imm      = imm;
    inBus.offset   = off;
    if (doStart) begin
      startIn  = 1'b1;
      baseAddr = base;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (inBus.ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk);
      #1;
      hsCyc = cyc;
    end else begin
      checkOutput("handshake_timeout", 32'd0, 32'd1);
    end
    inBus.valid = 1'b0;
    startIn     = 1'b0;
  endtask

  task automatic pulseStart(input logic [9:0] base);
    startIn  = 1'b1;
    baseAddr = base;
    tick();
    startIn  = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (!busyOut) break;
    end
    checkOutput("idle_reached", 32'(busyOut), 32'd0);
  endtask

  task automatic waitForWrite(input string tag, input logic [9:0] a);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (memBus.write && memBus.addr == a) found = 1'b1;
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    startIn         = 1'b0;
    baseAddr        = '0;
    inBus.valid     = 1'b0;
    inBus.mnemonic  = '0;
    inBus.rd        = '0;
    inBus.rt        = '0;
    inBus.rs        = '0;
    inBus.imm       = '0;
    inBus.offset    = '0;
    memBus.busywait = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_write", 32'(memBus.write), 32'd0);
    checkOutput("rst_addr",  32'(memBus.addr),  32'd0);
    checkOutput("rst_wdata", 32'(memBus.wdata), 32'd0);
    checkOutput("rst_count", 32'(countOut),     32'd0);
    checkOutput("rst_busy",  32'(busyOut),      32'd0);
    checkOutput("rst_err",   32'(errOut),       32'd0);
    checkOutput("rst_ready", 32'(inBus.ready),  32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Single add from 0x010, with first-byte latency
    pulseStart(10'h010);
    clearLog();
    applyStimulus(5'd2, 3'd4, 3'd2, 3'd1, 8'hAA, 8'h55, 1'b0, 10'h0);
    waitIdle(100);
    expectWord(32'h02040201, 10'h010);
    compareLog("add");
    if (logCyc.size() > 0) checkOutput("add_latency", 32'(logCyc[0]), 32'(hsCyc + 1));
    else checkOutput("add_latency", 32'hFFFF_FFFF, 32'(hsCyc + 1));
    checkOutput("add_count", 32'(countOut), 32'd1);
    checkOutput("add_busy",  32'(busyOut),  32'd0);

    // Back-to-back loadi and beq stream without a gap
    tick();
    clearLog();
    applyStimulus(5'd0, 3'd3, 3'd6, 3'd7, 8'h5A, 8'h11, 1'b0, 10'h0);
    applyStimulus(5'd7, 3'd5, 3'd1, 3'd2, 8'h33, 8'hFE, 1'b0, 10'h0);
    waitIdle(100);
    expectWord(32'h0003005A, 10'h014);
    expectWord(32'h07FE0102, 10'h018);
    compareLog("b2b");
    if (logCyc.size() == 8) checkOutput("b2b_span", 32'(logCyc[7] - logCyc[0]), 32'd7);
    else checkOutput("b2b_span", 32'hFFFF_FFFF, 32'd7);
    checkOutput("b2b_count", 32'(countOut), 32'd3);

    // Stall three cycles while B1 is presented
    tick();
    clearLog();
    applyStimulus(5'd3, 3'd1, 3'd2, 3'd3, 8'hCC, 8'hDD, 1'b0, 10'h0);
    waitForWrite("stall_b0_seen", 10'h01C);
    tick();
    memBus.busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_write", 32'(memBus.write), 32'd1);
      checkOutput("stall_addr",  32'(memBus.addr),  32'h01D);
      checkOutput("stall_wdata", 32'(memBus.wdata), 32'h02);
      checkOutput("stall_count", 32'(countOut),     32'd3);
      tick();
    end
    memBus.busywait = 1'b0;
    waitIdle(100);
    expectWord(32'h03010203, 10'h01C);
    compareLog("stall");
    checkOutput("stall_count_done", 32'(countOut), 32'd4);

    // Memory stuck busy: holding register plus four FIFO entries fill, then ready drops
    tick();
    pulseStart(10'h100);
    clearLog();
    memBus.busywait = 1'b1;
    applyStimulus(5'd1,  3'd5, 3'd7, 3'd6, 8'hAA, 8'hBB, 1'b0, 10'h0);
    applyStimulus(5'd6,  3'd7, 3'd7, 3'd7, 8'hFF, 8'h10, 1'b0, 10'h0);
    applyStimulus(5'd8,  3'd7, 3'd6, 3'd5, 8'h12, 8'h34, 1'b0, 10'h0);
    applyStimulus(5'd16, 3'd7, 3'd3, 3'd4, 8'h56, 8'h78, 1'b0, 10'h0);
    applyStimulus(5'd17, 3'd6, 3'd2, 3'd5, 8'h99, 8'h9A, 1'b0, 10'h0);
    @(negedge clk);
    checkOutput("full_ready", 32'(inBus.ready), 32'd0);
    checkOutput("full_count", 32'(countOut),    32'd0);
    checkOutput("full_nolog", 32'(logData.size()), 32'd0);
    tick();
    memBus.busywait = 1'b0;
    waitIdle(300);
    expectWord(32'h01050006, 10'h100);
    expectWord(32'h06100000, 10'h104);
    expectWord(32'h08070605, 10'h108);
    expectWord(32'h10000304, 10'h10C);
    expectWord(32'h11000299, 10'h110);
    compareLog("full");
    checkOutput("full_count_done", 32'(countOut), 32'd5);

    // Illegal mnemonic is swallowed and flags ERR until the next idle START
    tick();
    clearLog();
    applyStimulus(5'd20, 3'd1, 3'd1, 3'd1, 8'h01, 8'h01, 1'b0, 10'h0);
    @(negedge clk);
    checkOutput("ill_ready", 32'(inBus.ready), 32'd1);
    checkOutput("ill_err",   32'(errOut),      32'd1);
    checkOutput("ill_busy",  32'(busyOut),     32'd0);
    repeat (6) tick();
    checkOutput("ill_nolog", 32'(logData.size()), 32'd0);
    checkOutput("ill_count", 32'(countOut),        32'd5);
    pulseStart(10'h200);
    @(negedge clk);
    checkOutput("ill_err_clr",   32'(errOut),   32'd0);
    checkOutput("ill_count_clr", 32'(countOut), 32'd0);

    // START with handshake at 0x3FE wraps; then reset in the middle of the next word
    tick();
    clearLog();
    applyStimulus(5'd5, 3'd1, 3'd1, 3'd1, 8'h44, 8'h66, 1'b1, 10'h3FE);
    waitIdle(100);
    expectWord(32'h05010101, 10'h3FE);
    compareLog("wrap");
    checkOutput("wrap_count", 32'(countOut), 32'd1);
    tick();
    clearLog();
    applyStimulus(5'd10, 3'd2, 3'd5, 3'd6, 8'h07, 8'h77, 1'b0, 10'h0);
    waitForWrite("rst_b1_seen", 10'h003);
    tick();
    checkOutput("rst_b2_addr",  32'(memBus.addr),  32'h004);
    checkOutput("rst_b2_wdata", 32'(memBus.wdata), 32'h02);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_write", 32'(memBus.write), 32'd0);
    checkOutput("mid_rst_addr",  32'(memBus.addr),  32'd0);
    checkOutput("mid_rst_wdata", 32'(memBus.wdata), 32'd0);
    checkOutput("mid_rst_count", 32'(countOut),     32'd0);
    checkOutput("mid_rst_busy",  32'(busyOut),      32'd0);
    checkOutput("mid_rst_ready", 32'(inBus.ready),  32'd1);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("post_rst_log",   32'(logData.size()), 32'd2);
    checkOutput("post_rst_write", 32'(memBus.write),   32'd0);
    checkOutput("post_rst_count", 32'(countOut),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_word_loader.md
Name: instr_word_loader

Overview:
- Program loader for the 8-bit CPU; the encode-side counterpart of the instruction decoder.
- Accepts mnemonic-level instructions (mnemonic code plus operand fields) over a valid/ready handshake.
- Encodes each into the 32-bit instruction word {OPCODE[31:24], F2[23:16], F1[15:8], F0[7:0]} and queues it in a small FIFO.
- Writes each word byte-serially, little-endian, into byte-addressed instruction memory using the memory BUSYWAIT protocol.

Parameters:
- ADDR_W, 10, instruction-memory byte address width; addresses wrap modulo 2^ADDR_W.
- DEPTH, 4, FIFO entries (power of 2, >=2); a separate holding register sits in addition to the FIFO.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  pulse; loads write pointer from BASE_ADDR, clears COUNT and ERR.
- BASE_ADDR  in  ADDR_W  start byte address.
- IN_VALID  in  1  instruction present.
- IN_READY  out  1  loader can accept.
- MNEMONIC  in  5  codes 0..17: loadi,mov,add,sub,and,or,j,beq,mult,sll,srl,sra,ror,bne,lwd,lwi,swd,swi; code equals OPCODE.
- RD, RT, RS  in  3 each  register numbers, zero-extended to 8 bits when placed.
- IMM  in  8  immediate.
- OFFSET  in  8  branch/jump offset.
- MEM_ADDR  out  ADDR_W  byte address.
- MEM_WRITEDATA  out  8  byte data.
- MEM_WRITE  out  1  write request.
- MEM_BUSYWAIT  in  1  memory stall.
- COUNT  out  16  instructions fully committed since START; wraps.
- BUSY  out  1  FIFO non-empty, or FSM not IDLE.
- ERR  out  1  sticky illegal-mnemonic flag.

Behaviour:
- Reset (async): FIFO emptied; FSM to IDLE; write pointer=0. Outputs: MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0, COUNT=0, BUSY=0, ERR=0, IN_READY=1. A partially written instruction is abandoned, with no completion of remaining bytes.
- Handshake: an instruction is transferred at a rising edge where IN_VALID=1 and IN_READY=1. IN_READY = !FIFO_full.
- Illegal MNEMONIC (>17): consumed, not enqueued, ERR<=1.
- Encoding, fields listed as F2,F1,F0:
  - add/sub/and/or/mult: RD,RT,RS.
  - mov/lwd: RD,0,RS.
  - loadi/lwi/sll/srl/sra/ror: RD,0,IMM.
  - j: OFFSET,0,0.
  - beq/bne: OFFSET,RT,RS.
  - swd: 0,RT,RS.
  - swi: 0,RT,IMM.
- FSM states: IDLE, B0, B1, B2, B3.
  - IDLE: if FIFO non-empty, pop into the holding register and go to B0.
  - Bn: MEM_WRITE=1, MEM_ADDR=ptr, MEM_WRITEDATA=word[8n+7:8n].
  - A byte is accepted at an edge with MEM_WRITE=1 and MEM_BUSYWAIT=0. On acceptance, ptr<=ptr+1 (wrap) and the FSM advances. While BUSYWAIT=1, address and data are held stable.
  - On B3 acceptance: COUNT<=COUNT+1. If FIFO non-empty, pop in the same edge and go to B0 with no bubble; else go to IDLE with MEM_WRITE=0.
- Latency: from idle, B0 is presented in the 2nd cycle after the handshake edge. Sustained throughput is 4 cycles per instruction with BUSYWAIT low.
- Push and pop on the same edge are allowed; occupancy is unchanged.
- START: honoured only when BUSY=0 (ptr<=BASE_ADDR, COUNT<=0, ERR<=0); ignored when BUSY=1. If START coincides with a handshake while idle, both take effect; the new instruction uses BASE_ADDR.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: adds output CHECKSUM[7:0], the modulo-256 sum of every accepted byte since START or RESET; it updates on the edge of each byte acceptance.
- Undefined: CHECKSUM is absent and no adder is built; all other behaviour is identical.

Test Plan:
- RESET, START BASE_ADDR=0x010, push add RD=4 RT=2 RS=1 -> word 0x02040201; bytes 01,02,04,02 at 0x010..0x013; COUNT=1; BUSY returns to 0.
- Push loadi RD=3 IMM=0x5A, then beq OFFSET=0xFE RT=1 RS=2 back-to-back -> bytes 5A,00,03,00 then 02,01,FE,07. Second B0 directly follows first B3 with no gap; total 8 consecutive MEM_WRITE cycles.
- Hold MEM_BUSYWAIT=1 for 3 cycles during B1 -> MEM_ADDR/MEM_WRITEDATA unchanged for those cycles; COUNT increments only after B3 acceptance.
- MEM_BUSYWAIT stuck at 1, push continuously -> DEPTH+1 (5) instructions accepted, then IN_READY=0. Release BUSYWAIT -> all 5 written in order, COUNT=5.
- Push MNEMONIC=20 -> IN_READY stays 1, ERR=1, no MEM_WRITE, COUNT unchanged. Following idle START -> ERR=0.
- ADDR_W=10, BASE_ADDR=0x3FE, one instruction -> addresses 0x3FE,0x3FF,0x000,0x001. RESET asserted during B2 of a second instruction -> outputs immediately at reset values, no further writes.
